// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine over a synchronous-read word memory
module load_store_unit #(
    parameter int ADDR_WIDTH = 13,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [BUS_WIDTH-1:0]   req_addr,
    input  logic [BUS_WIDTH-1:0]   req_wdata,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    output logic                   resp_valid,
    output logic [BUS_WIDTH-1:0]   resp_rdata,
    output logic                   resp_error,
    output logic [BUS_WIDTH-1:0]   mem_addr,
    output logic [BUS_WIDTH/8-1:0] mem_we,
    output logic [BUS_WIDTH-1:0]   mem_wdata,
    input  logic [BUS_WIDTH-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    state_t state, state_next;
    logic we_q, uns_q, err_q, accept, req_err;
    logic [1:0] size_q, off_q;
    logic [BUS_WIDTH-1:0] rdata_q, lane, ext;
    logic [BUS_WIDTH/8-1:0] we_mask;
    assign accept  = req_valid & req_ready;
    assign req_err = (req_size == 2'b11) |
                     ((req_size == 2'b01) & req_addr[0]) |
                     ((req_size == 2'b10) & (req_addr[1:0] != 2'b00)) |
                     ((req_addr >> ADDR_WIDTH) != '0);
    // state register; reset aborts any outstanding access
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    // next-state: errors skip the memory phases and respond immediately
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_err ? DONE : ACCESS;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end
    // capture the request; memory address/data only move on a legal request
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            err_q  <= req_err;
            size_q <= req_size;
            off_q  <= req_addr[1:0];
            if (!req_err) begin
                mem_addr  <= {req_addr[BUS_WIDTH-1:2], 2'b00};
                mem_wdata <= (req_size == 2'b00) ? {4{req_wdata[7:0]}} :
                             (req_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
            end
        end
    end
    // lane select and extension of the read word
    always_comb begin
        lane    = mem_rdata >> {off_q, 3'b000};
        ext     = (size_q == 2'b00) ? {{(BUS_WIDTH-8){~uns_q & lane[7]}}, lane[7:0]} :
                  (size_q == 2'b01) ? {{(BUS_WIDTH-16){~uns_q & lane[15]}}, lane[15:0]} : lane;
        we_mask = (size_q == 2'b00) ? 4'b0001 << off_q :
                  (size_q == 2'b01) ? 4'b0011 << off_q : 4'b1111;
    end
    // load data is registered in CAPTURE and cleared after the response cycle
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= (state == CAPTURE && !we_q) ? ext : '0;
    end
    assign req_ready  = (state == IDLE);
    assign mem_we     = (state == ACCESS && we_q && !rst) ? we_mask : '0;
    assign resp_valid = (state == DONE) & ~rst;
    assign resp_error = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit
module tb_load_store_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0] req_size = 2'b00;
    logic req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0] mem_we;
    logic [31:0] mem [0:2047];
    int checks = 0, errors = 0, ncyc = 0;
    typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
    exp_t sb[$];

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    // synchronous-read memory with byte-lane writes
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_addr[12:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        mem_rdata <= mem[mem_addr[12:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: pop expected response whenever the DUT presents one
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", {31'b0, resp_error}, {31'b0, e.err});
                check("resp_cycle", ncyc, e.cyc);
            end
        end else if (!rst) begin
            check("idle_rdata", resp_rdata, 32'h0);
            check("idle_error", {31'b0, resp_error}, 32'h0);
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic err,
                         input logic [31:0] rdata, input logic [3:0] we_exp,
                         input logic [31:0] wdata_exp);
        int k, n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        k = ncyc;
        e.rdata = rdata; e.err = err; e.cyc = k + (err ? 1 : 3);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        check("mem_we_access", {28'b0, mem_we}, {28'b0, (!err && we) ? we_exp : 4'b0});
        check("req_ready_busy", {31'b0, req_ready}, 32'h0);
        if (!err) begin
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (we) check("mem_wdata", mem_wdata, wdata_exp);
        end
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            check("mem_we_after", {28'b0, mem_we}, 32'h0);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=pending required=done");
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[11'h040] = 32'h12FF3456;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_mem_we", {28'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        //    we    addr          wdata         sz     uns   err   rdata         we     wdata
        issue(1'b0, 32'h102,  32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 4'h0, 32'h0);
        issue(1'b0, 32'h102,  32'h0,        2'b00, 1'b1, 1'b0, 32'h000000FF, 4'h0, 32'h0);
        issue(1'b1, 32'h103,  32'h000000A5, 2'b00, 1'b0, 1'b0, 32'h0,        4'h8, 32'hA5A5A5A5);
        issue(1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 1'b0, 32'hA5FF3456, 4'h0, 32'h0);
        issue(1'b1, 32'h100,  32'h80011234, 2'b10, 1'b0, 1'b0, 32'h0,        4'hF, 32'h80011234);
        issue(1'b0, 32'h102,  32'h0,        2'b01, 1'b0, 1'b0, 32'hFFFF8001, 4'h0, 32'h0);
        issue(1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 1'b0, 32'h80011234, 4'h0, 32'h0);
        issue(1'b0, 32'h100,  32'h0,        2'b01, 1'b1, 1'b0, 32'h00001234, 4'h0, 32'h0);
        issue(1'b1, 32'h102,  32'h0000BEEF, 2'b01, 1'b0, 1'b0, 32'h0,        4'hC, 32'hBEEFBEEF);
        issue(1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 1'b0, 32'hBEEF1234, 4'h0, 32'h0);
        issue(1'b0, 32'h101,  32'h0,        2'b00, 1'b0, 1'b0, 32'h00000012, 4'h0, 32'h0);
        issue(1'b0, 32'h103,  32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFFBE, 4'h0, 32'h0);
        issue(1'b1, 32'h1FFF, 32'h0000005A, 2'b00, 1'b0, 1'b0, 32'h0,        4'h8, 32'h5A5A5A5A);
        issue(1'b0, 32'h1FFF, 32'h0,        2'b00, 1'b1, 1'b0, 32'h0000005A, 4'h0, 32'h0);
        issue(1'b1, 32'h101,  32'h11111111, 2'b10, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0);
        issue(1'b0, 32'h2000, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0);
        issue(1'b1, 32'h2000, 32'h22222222, 2'b00, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0);
        issue(1'b0, 32'h100,  32'h0,        2'b11, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0);
        issue(1'b0, 32'h101,  32'h0,        2'b01, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
        req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_access_we", {28'b0, mem_we}, 32'hF);
        rst = 1'b1;
        #1;
        check("abort_rst_we", {28'b0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", {31'b0, req_ready}, 32'h1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("abort_mem_we", {28'b0, mem_we}, 32'h0);
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h100,  32'h0,        2'b10, 1'b0, 1'b0, 32'hBEEF1234, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
